// File: rtl/ps2_kbd_rx_pkg.sv
// Shared PS/2 keyboard constants, the frame-to-FIFO write record and the frame check.
package ps2_kbd_rx_pkg;
  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;

  typedef struct packed {
    logic       vld;
    logic [7:0] code;
  } ps2_wr_t;

  // sh holds {par, d7..d0, start} once ten bits are in; stop is the bit arriving now.
  function automatic logic frame_ok(input logic [9:0] sh, input logic stop);
    return !sh[0] && stop && (^sh[9:1]);
  endfunction
endpackage

// File: rtl/ps2_fifo.sv
// Show-ahead FIFO with wrap-bit pointers; a push into a full FIFO is accepted only alongside a pop.
module ps2_fifo #(
  parameter int AW = 3,
  parameter int W  = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin sync, 11-bit frame deserialiser with mid-frame timeout, scan-code FIFO.
module ps2_kbd_rx
  import ps2_kbd_rx_pkg::*;
#(
  parameter int FIFO_AW     = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);
  localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev, fe;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] tmo_cnt;
  ps2_wr_t       wr;
  logic          full, empty, pop_fire;

  always_ff @(posedge clk) begin
    if (clr) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_prev <= clk_sync[1];
    end
  end

  assign fe = clk_prev && !clk_sync[1];

  always_ff @(posedge clk) begin
    if (clr) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      tmo_cnt   <= '0;
      wr        <= '0;
      frame_err <= 1'b0;
    end else begin
      wr.vld    <= 1'b0;
      frame_err <= 1'b0;
      if (fe) begin
        tmo_cnt <= '0;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
          if (frame_ok(shreg, dat_sync[1])) wr <= '{vld: 1'b1, code: shreg[8:1]};
          else                              frame_err <= 1'b1;
        end else begin
          shreg   <= {dat_sync[1], shreg[9:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (bit_cnt == '0) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
        // Stalled mid-frame: drop the partial frame quietly and wait for a new start bit.
        tmo_cnt <= '0;
        bit_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  assign pop_fire = !nextdata_n && !empty;
  assign ready    = !empty;

  always_ff @(posedge clk) begin
    if (clr)                          overflow <= 1'b0;
    else if (wr.vld && full && !pop_fire) overflow <= 1'b1;
  end

  ps2_fifo #(.AW(FIFO_AW), .W(8)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (wr.vld),
    .pop   (!nextdata_n),
    .din   (wr.code),
    .dout  (data),
    .full  (full),
    .empty (empty)
  );
endmodule
